decoder_top: RTL and testbench
==============================

// Module: decoder_top
// PURPOSE
//  Constant-weight (CW) to binary decoder, 20-8 configuration.
//  - Host loads N_WORDS CW_W-bit words (MSB-first stream, word 0 first) into a buffer, then pulses start.
//  - Block scans the stream bit by bit and emits the recovered binary message serially on bin_msg.
//  - Inverse of the team's fixed-d (d=2^U) run-length CW encoder; sits between the CW channel and the message sink.
// PARAMETERS
//  CW_W     20  width of one loaded word (bits)
//  N_WORDS  8   words per CW block (stream length L = CW_W*N_WORDS = 160)
//  U        3   run-length field width; run threshold D = 2^U = 8
// PORTS
//  clk       in   1     single clock, rising edge
//  rst_b     in   1     reset, asynchronous, active-high (name kept per codebase)
//  start     in   1     1-cycle pulse: begin decoding buffer contents
//  msg_bype  in   CW_W  CW word to load
//  wr_en     in   1     write msg_bype into buffer[wr_ptr]
//  bin_msg   out  1     decoded message bit, valid when msg_rdy=1
//  msg_rdy   out  1     bin_msg valid strobe (one bit per high cycle)
//  msg_done  out  1     1-cycle pulse: block fully decoded
// BEHAVIOUR
//  Reset: bin_msg=0, msg_rdy=0, msg_done=0, wr_ptr=0, state=IDLE, zero counter=0; buffer contents undefined.
//  Load (IDLE only): wr_en=1 at edge -> buffer[wr_ptr]<=msg_bype, wr_ptr<=wr_ptr+1 mod N_WORDS (9th write overwrites word 0).
//   wr_en ignored outside IDLE.
//  Stream order: bit k (0..L-1) = buffer[k/CW_W][CW_W-1-(k%CW_W)], i.e. word 0 bit 19 first.
//  FSM: IDLE -start-> SCAN <-> EMIT -> DONE -> IDLE. start ignored outside IDLE; start+wr_en same cycle: write done, then start taken.
//  SCAN: one stream bit per cycle, 8-bit index k, U-bit zero counter cnt.
//   - bit=0, cnt<D-1: cnt++.
//   - bit=0, cnt=D-1: emit '1', cnt<=0.
//   - bit=1: emit '0' then cnt as U bits MSB-first (U+1 bits total); cnt<=0.
//   - Emitted bits appear on bin_msg with msg_rdy=1, first bit the cycle after the bit is examined.
//   - EMIT holds the scan until the U+1 bits are out, one per cycle, then SCAN resumes at k+1.
//  End: after bit L-1 is examined and any EMIT finishes -> DONE.
//   - Leftover cnt (trailing zeros < D) discarded as padding.
//   - DONE drives msg_done=1 for exactly one cycle, msg_rdy=0, wr_ptr<=0, then IDLE.
//  msg_rdy=0 in IDLE/DONE and on non-emitting SCAN cycles; bin_msg holds last value when msg_rdy=0.
//  Decoding never looks ahead; total cycles start->msg_done = L + (U * number_of_ones) + 2.
//  rst_b mid-decode: immediate abort to reset state, no msg_done; buffer not cleared.
//  start with no prior writes decodes stale buffer contents; no error flag.
// TESTING
//  1 Reset: rst_b=1 asynchronously mid-SCAN -> bin_msg, msg_rdy, msg_done all 0 without a clock edge; after release, no msg_done.
//  2 Load 32938,93735,56609,11423,169931,216429,290567,146104 then start.
//    First 20 msg_rdy bits = 0100 0111 0001 0001 0001.
//    Then exactly one msg_done pulse, no msg_rdy after it.
//  3 All 8 words = 0 -> exactly 20 bits, all '1'.
//    msg_done 162 cycles after start.
//  4 All 8 words = 20'hFFFFF -> 640 bits, repeating "0000" (160 groups).
//    msg_done at start+642.
//  5 Write 9 words (word0=A, ..., 9th=B) then start -> decode uses B as word 0.
//    Start or wr_en during decode ignored; second block after msg_done reloads from wr_ptr=0.

Source files
------------

// File: rtl/decoder_if.sv
// Handshake/bus bundle for the constant-weight to binary decoder.
// Ports (slave view):
//   start    in   1-cycle pulse, begin decoding the buffer
//   msg_bype in   CW word to load
//   wr_en    in   write msg_bype into buffer[wr_ptr]
//   bin_msg  out  decoded message bit
//   msg_rdy  out  bin_msg valid strobe
//   msg_done out  1-cycle pulse, block fully decoded
interface decoder_if #(
    parameter int CW_W = 20
);
    logic            start;
    logic [CW_W-1:0] msg_bype;
    logic            wr_en;
    logic            bin_msg;
    logic            msg_rdy;
    logic            msg_done;

    modport master (
        output start, msg_bype, wr_en,
        input  bin_msg, msg_rdy, msg_done
    );

    modport slave (
        input  start, msg_bype, wr_en,
        output bin_msg, msg_rdy, msg_done
    );
endinterface

// File: rtl/decoder_top.sv
// Constant-weight to binary decoder (20-8 configuration).
// Host loads N_WORDS words into a buffer, pulses start, and the block
// scans the CW stream MSB-first, emitting the binary message serially.
// Ports:
//   clk    in  single clock, rising edge
//   rst_b  in  asynchronous reset, active-high
//   bus    decoder_if.slave: start, msg_bype, wr_en in;
//          bin_msg, msg_rdy, msg_done out
module decoder_top #(
    parameter int CW_W    = 20,
    parameter int N_WORDS = 8,
    parameter int U       = 3
) (
    input  logic      clk,
    input  logic      rst_b,
    decoder_if.slave  bus
);
    localparam int D  = 1 << U;
    localparam int PW = $clog2(N_WORDS);
    localparam int BW = $clog2(CW_W);
    localparam int RW = $clog2(U + 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_w_q, rd_w_d;
    logic [BW-1:0]   rd_b_q, rd_b_d;
    logic [U-1:0]    cnt_q, cnt_d;
    logic [U-1:0]    emit_q, emit_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic            last_q, last_d;
    logic            bin_q, bin_d;
    logic            rdy_q, rdy_d;
    logic            done_q, done_d;

    logic [CW_W-1:0] buf_q [N_WORDS];

    logic            cur_bit;
    logic            last_bit;
    logic            wr_ok;

    assign cur_bit  = buf_q[rd_w_q][rd_b_q];
    assign last_bit = (rd_w_q == PW'(N_WORDS - 1)) && (rd_b_q == '0);
    assign wr_ok    = bus.wr_en && (state_q == IDLE);

    // Buffer has no reset: contents survive rst_b and stale data
    // is decoded if start arrives without fresh writes.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            buf_q[wr_ptr_q] <= bus.msg_bype;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_w_q   <= '0;
            rd_b_q   <= '0;
            cnt_q    <= '0;
            emit_q   <= '0;
            rem_q    <= '0;
            last_q   <= 1'b0;
            bin_q    <= 1'b0;
            rdy_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_w_q   <= rd_w_d;
            rd_b_q   <= rd_b_d;
            cnt_q    <= cnt_d;
            emit_q   <= emit_d;
            rem_q    <= rem_d;
            last_q   <= last_d;
            bin_q    <= bin_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_w_d   = rd_w_q;
        rd_b_d   = rd_b_q;
        cnt_d    = cnt_q;
        emit_d   = emit_q;
        rem_d    = rem_q;
        last_d   = last_q;
        bin_d    = bin_q;
        rdy_d    = 1'b0;
        done_d   = 1'b0;

        if (wr_ok) begin
            if (wr_ptr_q == PW'(N_WORDS - 1)) begin
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    rd_w_d  = '0;
                    rd_b_d  = BW'(CW_W - 1);
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                // Advance the read pointer every examined bit;
                // the emit path remembers whether this was the last.
                if (rd_b_q == '0) begin
                    rd_b_d = BW'(CW_W - 1);
                    rd_w_d = rd_w_q + 1'b1;
                end else begin
                    rd_b_d = rd_b_q - 1'b1;
                end
                last_d = last_bit;
                if (cur_bit) begin
                    // '0' goes out now, the U-bit run length follows.
                    rdy_d   = 1'b1;
                    bin_d   = 1'b0;
                    emit_d  = cnt_q;
                    rem_d   = RW'(U);
                    cnt_d   = '0;
                    state_d = EMIT;
                end else begin
                    if (cnt_q == U'(D - 1)) begin
                        rdy_d = 1'b1;
                        bin_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Trailing zeros short of a full run are dropped.
                    if (last_bit) begin
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                rdy_d  = 1'b1;
                bin_d  = emit_q[U-1];
                emit_d = emit_q << 1;
                rem_d  = rem_q - 1'b1;
                if (rem_q == RW'(1)) begin
                    state_d = last_q ? DONE : SCAN;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                wr_ptr_d = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.bin_msg  = bin_q;
    assign bus.msg_rdy  = rdy_q;
    assign bus.msg_done = done_q;
endmodule

// File: tb/tb_decoder_top.sv
// Self-checking bench for decoder_top.
// Scoreboard of expected message bits, filled by a stream model.
module tb_decoder_top;
    localparam int CW_W = 20;
    localparam int N    = 8;
    localparam int U    = 3;
    localparam int D    = 8;
    localparam int L    = CW_W * N;

    logic clk = 1'b0;
    logic rst_b;

    always #5 clk = ~clk;

    decoder_if #(.CW_W(CW_W)) bus ();

    decoder_top #(
        .CW_W(CW_W),
        .N_WORDS(N),
        .U(U)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .bus(bus)
    );

    int          errors = 0;
    int          checks = 0;
    bit          exp_q[$];
    bit          rx_q[$];
    logic [19:0] mw[N];
    int          model_ones;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model();
        int cnt;
        bit b;
        cnt = 0;
        model_ones = 0;
        exp_q.delete();
        for (int k = 0; k < L; k++) begin
            b = mw[k / CW_W][CW_W - 1 - (k % CW_W)];
            if (b) begin
                model_ones++;
                exp_q.push_back(1'b0);
                for (int j = U - 1; j >= 0; j--) exp_q.push_back(cnt[j]);
                cnt = 0;
            end else if (cnt == D - 1) begin
                exp_q.push_back(1'b1);
                cnt = 0;
            end else begin
                cnt++;
            end
        end
    endfunction

    task automatic write_word(input logic [19:0] v);
        bus.wr_en    = 1'b1;
        bus.msg_bype = v;
        step();
        bus.wr_en    = 1'b0;
    endtask

    task automatic load8();
        for (int i = 0; i < N; i++) write_word(mw[i]);
    endtask

    // Start is counted as cycle 0; done_cyc is the cycle msg_done is seen.
    task automatic run_block(input bit disturb, output int done_cyc);
        int cyc;
        int pulses;
        int limit;
        bit want;
        pulses   = 0;
        done_cyc = -1;
        limit    = L + U * model_ones + 40;
        rx_q.delete();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (cyc <= limit) begin
            if (bus.msg_rdy === 1'b1) begin
                rx_q.push_back(bus.bin_msg);
                checks++;
                if (done_cyc >= 0) begin
                    errors++;
                    $display("FAIL rdy_after_done cyc=%0d got=1 want=0", cyc);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit cyc=%0d got=%b want=none",
                             cyc, bus.bin_msg);
                end else begin
                    want = exp_q.pop_front();
                    if (bus.bin_msg !== want) begin
                        errors++;
                        $display("FAIL bin_msg bit=%0d got=%b want=%b",
                                 rx_q.size() - 1, bus.bin_msg, want);
                    end
                end
            end
            if (bus.msg_done === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (disturb) begin
                if (cyc == 10) begin
                    bus.start    = 1'b1;
                    bus.wr_en    = 1'b1;
                    bus.msg_bype = 20'h5A5A5;
                end else begin
                    bus.start = 1'b0;
                    bus.wr_en = 1'b0;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 10) break;
            step();
            cyc++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL done_pulses got=%0d want=1", pulses);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL missing_bits got=%0d want=0 left", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_b        = 1'b1;
        bus.start    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.msg_bype = '0;
        repeat (3) step();
        checks++;
        if (bus.bin_msg !== 1'b0) begin
            errors++;
            $display("FAIL rst_bin got=%b want=0", bus.bin_msg);
        end
        checks++;
        if (bus.msg_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_rdy got=%b want=0", bus.msg_rdy);
        end
        checks++;
        if (bus.msg_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_done got=%b want=0", bus.msg_done);
        end
        rst_b = 1'b0;
        step();
    endtask

    task automatic test_pattern();
        int          dc;
        logic [19:0] pat;
        mw = '{20'd32938, 20'd93735, 20'd56609, 20'd11423,
               20'd169931, 20'd216429, 20'd290567, 20'd146104};
        pat = 20'b0100_0111_0001_0001_0001;
        load8();
        model();
        run_block(1'b0, dc);
        checks++;
        if (rx_q.size() < 20) begin
            errors++;
            $display("FAIL pat_len got=%0d want>=20", rx_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rx_q[i] !== pat[19-i]) begin
                    errors++;
                    $display("FAIL pat_bit%0d got=%b want=%b",
                             i, rx_q[i], pat[19-i]);
                end
            end
        end
        checks++;
        if (dc !== L + U * model_ones + 2) begin
            errors++;
            $display("FAIL pat_latency got=%0d want=%0d",
                     dc, L + U * model_ones + 2);
        end
    endtask

    task automatic test_async_reset();
        int  n;
        bit  hit;
        bit  saw_rdy;
        bit  saw_done;
        hit = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (n < 100 && !hit) begin
            if (bus.msg_rdy === 1'b1 && bus.bin_msg === 1'b1) hit = 1'b1;
            else step();
            n++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL ar_find got=none want=rdy&bin");
        end
        #2;
        rst_b = 1'b1;
        #1;
        checks++;
        if (bus.bin_msg !== 1'b0 || bus.msg_rdy !== 1'b0 ||
            bus.msg_done !== 1'b0) begin
            errors++;
            $display("FAIL ar_outs got=%b%b%b want=000",
                     bus.bin_msg, bus.msg_rdy, bus.msg_done);
        end
        step();
        step();
        rst_b = 1'b0;
        saw_rdy  = 1'b0;
        saw_done = 1'b0;
        repeat (200) begin
            step();
            if (bus.msg_rdy === 1'b1) saw_rdy = 1'b1;
            if (bus.msg_done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL ar_no_done got=1 want=0");
        end
        checks++;
        if (saw_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ar_no_rdy got=1 want=0");
        end
    endtask

    task automatic test_stale();
        int dc;
        model();
        run_block(1'b0, dc);
        checks++;
        if (dc !== L + U * model_ones + 2) begin
            errors++;
            $display("FAIL stale_latency got=%0d want=%0d",
                     dc, L + U * model_ones + 2);
        end
    endtask

    task automatic test_zeros();
        int dc;
        int bad;
        for (int i = 0; i < N; i++) mw[i] = 20'h00000;
        load8();
        model();
        run_block(1'b0, dc);
        checks++;
        if (rx_q.size() !== 20) begin
            errors++;
            $display("FAIL zero_len got=%0d want=20", rx_q.size());
        end
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== 1'b1) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL zero_val got=%0d zeros want=0", bad);
        end
        checks++;
        if (dc !== 162) begin
            errors++;
            $display("FAIL zero_latency got=%0d want=162", dc);
        end
    endtask

    task automatic test_ones();
        int dc;
        int bad;
        for (int i = 0; i < N; i++) mw[i] = 20'hFFFFF;
        load8();
        model();
        run_block(1'b0, dc);
        checks++;
        if (rx_q.size() !== 640) begin
            errors++;
            $display("FAIL ones_len got=%0d want=640", rx_q.size());
        end
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== 1'b0) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ones_val got=%0d ones want=0", bad);
        end
        checks++;
        if (dc !== 642) begin
            errors++;
            $display("FAIL ones_latency got=%0d want=642", dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        write_word(20'hABCDE);
        for (int i = 1; i < N; i++) begin
            mw[i] = 20'($urandom);
            write_word(mw[i]);
        end
        mw[0] = 20'h13579;
        write_word(mw[0]);
        model();
        run_block(1'b1, dc);
        checks++;
        if (dc !== L + U * model_ones + 2) begin
            errors++;
            $display("FAIL wrap_latency got=%0d want=%0d",
                     dc, L + U * model_ones + 2);
        end
        for (int i = 0; i < N; i++) mw[i] = 20'($urandom);
        load8();
        model();
        run_block(1'b0, dc);
        checks++;
        if (dc !== L + U * model_ones + 2) begin
            errors++;
            $display("FAIL reload_latency got=%0d want=%0d",
                     dc, L + U * model_ones + 2);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_async_reset();
        test_stale();
        test_zeros();
        test_ones();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
